// File: rtl/bus_arbiter4_pkg.sv
// rtl/bus_arbiter4_pkg.sv - shared types, sizes and encoder helpers for bus_arbiter4
package bus_arbiter4_pkg;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Highest set index wins; returns 0 for an all-zero vector.
    function automatic logic [ID_W-1:0] prio_enc4(input logic [NUM_SRC-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot4(input logic [ID_W-1:0] id);
        return NUM_SRC'(1) << id;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// rtl/bus_arbiter4_rr_pick4.sv - combinational winner select, round-robin or fixed priority
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    input  logic               rr_en_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);

    logic [ID_W-1:0] rr_id;
    logic [ID_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the source right after last_id wins.
    always_comb begin
        rr_id = '0;
        idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = last_id_i + ID_W'(k) + ID_W'(1);
            if (req_i[idx]) begin
                rr_id = idx;
            end
        end
    end

    assign winner_o = rr_en_i ? rr_id : prio_enc4(req_i);
    assign any_o    = |req_i;

endmodule

// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - four-source tri-state bus arbiter with hold timeout and turnaround gap
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rr_en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       busy,
    output logic       preempt
);

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = (TURN_CYC == 0) ? '0 : CNT_W'(TURN_CYC - 1);
    localparam logic             HOLD_ON   = (MAX_HOLD != 0);

    arb_state_e          state_q;
    logic [NUM_SRC-1:0]  gnt_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic                gnt_valid_q;
    logic                busy_q;
    logic                preempt_q;
    logic [CNT_W-1:0]    hold_cnt_q;
    logic [CNT_W-1:0]    turn_cnt_q;
    logic [ID_W-1:0]     last_id_q;

    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                owner_req;
    logic                others_wait;
    logic                hold_expired;

    rr_pick4 u_pick (
        .req_i     (req),
        .last_id_i (last_id_q),
        .rr_en_i   (rr_en),
        .winner_o  (pick_id),
        .any_o     (pick_any)
    );

    assign owner_req   = req[gnt_id_q];
    assign others_wait = (req & ~gnt_q) != '0;
    // >= rather than == so a saturated counter still preempts as soon as someone else asks.
    assign hold_expired = HOLD_ON && (hold_cnt_q >= HOLD_LAST) && others_wait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            turn_cnt_q  <= '0;
            last_id_q   <= ID_W'(NUM_SRC - 1);
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q     <= GRANT;
                        gnt_q       <= onehot4(pick_id);
                        gnt_id_q    <= pick_id;
                        gnt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_expired) begin
                        state_q     <= TURN;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        turn_cnt_q  <= '0;
                        last_id_q   <= gnt_id_q;
                        preempt_q   <= owner_req;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                TURN: begin
                    // The last gap cycle arbitrates directly so the gap is exactly TURN_CYC.
                    if (turn_cnt_q == TURN_LAST) begin
                        if (pick_any) begin
                            state_q     <= GRANT;
                            gnt_q       <= onehot4(pick_id);
                            gnt_id_q    <= pick_id;
                            gnt_valid_q <= 1'b1;
                            hold_cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        turn_cnt_q <= turn_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = busy_q;
    assign preempt   = preempt_q;

endmodule
